id_ex_stage: RTL and testbench

- Pipeline register between decode (ID) and execute (EX) of the 5-stage MIPS core.
- Captures decoded operands and control, and resolves data hazards:
  - forwards from MEM and WB,
  - detects load-use hazards and inserts a bubble,
  - keeps forwarded values across stalls.
- Drives the ALU operand/opcode inputs (a, b, oper) directly, plus store data and writeback control for EX/MEM.

---
 rtl/id_ex_stage.sv | 218 +++++++++++++++++++++
 tb/tb_id_ex_stage.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS core.
// Holds the decoded instruction for the execute stage, and resolves data
// hazards. It forwards MEM/WB results onto the ALU operands and store data.
// It detects load-use hazards and inserts a bubble. It keeps forwarded
// operand values across downstream stalls.
//
// Flow control:
// - ex_flush kills the EX slot at the next edge, and takes precedence over
//   ex_stall.
// - ex_stall freezes the EX slot. Only the operand data is refreshed, so
//   that a forwarded value stays valid after its producer retires.
// - load_use_stall asks upstream to hold PC and IF/ID for one cycle. During
//   that cycle this stage loads a bubble instead of the ID instruction.
module id_ex_stage #(
    parameter bit FWD_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [31:0] id_pc4,
    input  logic [4:0]  id_rs_addr,
    input  logic [4:0]  id_rt_addr,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_shamt,
    input  logic [1:0]  id_a_sel,
    input  logic        id_b_sel,
    input  logic [3:0]  id_alu_oper,
    input  logic        id_wb_en,
    input  logic [4:0]  id_wb_addr,
    input  logic        id_is_load,
    input  logic        ex_stall,
    input  logic        ex_flush,
    input  logic        mem_wb_en,
    input  logic [4:0]  mem_wb_addr,
    input  logic [31:0] mem_wb_data,
    input  logic        wb_wb_en,
    input  logic [4:0]  wb_wb_addr,
    input  logic [31:0] wb_wb_data,
    output logic        load_use_stall,
    output logic        ex_valid,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_oper,
    output logic [31:0] ex_store_data,
    output logic        ex_wb_en,
    output logic [4:0]  ex_wb_addr,
    output logic        ex_is_load
);

    // A-operand source selects
    localparam logic [1:0] A_SEL_RS    = 2'd0;
    localparam logic [1:0] A_SEL_SHAMT = 2'd1;
    localparam logic [1:0] A_SEL_PC4   = 2'd2;
    localparam logic [1:0] A_SEL_ZERO  = 2'd3;

    // Registered EX-stage fields
    logic        valid_q,   valid_d;
    logic [31:0] pc4_q,     pc4_d;
    logic [4:0]  rs_addr_q, rs_addr_d;
    logic [4:0]  rt_addr_q, rt_addr_d;
    logic [31:0] rs_data_q, rs_data_d;
    logic [31:0] rt_data_q, rt_data_d;
    logic [31:0] imm_q,     imm_d;
    logic [4:0]  shamt_q,   shamt_d;
    logic [1:0]  a_sel_q,   a_sel_d;
    logic        b_sel_q,   b_sel_d;
    logic [3:0]  oper_q,    oper_d;
    logic        wb_en_q,   wb_en_d;
    logic [4:0]  wb_addr_q, wb_addr_d;
    logic        is_load_q, is_load_d;

    // Forwarded source operands
    logic [31:0] fwd_rs;
    logic [31:0] fwd_rt;

    // Hazard match terms
    logic        ex_load_pending;
    logic        rs_hit;
    logic        rt_hit;

    // Forward rs. MEM is younger than WB, so MEM wins. $0 never forwards.
    always_comb begin
        fwd_rs = rs_data_q;
        if (FWD_EN && (rs_addr_q != 5'd0)) begin
            if (mem_wb_en && (mem_wb_addr == rs_addr_q)) begin
                fwd_rs = mem_wb_data;
            end else if (wb_wb_en && (wb_wb_addr == rs_addr_q)) begin
                fwd_rs = wb_wb_data;
            end
        end
    end

    // Forward rt with the same priority rule as rs
    always_comb begin
        fwd_rt = rt_data_q;
        if (FWD_EN && (rt_addr_q != 5'd0)) begin
            if (mem_wb_en && (mem_wb_addr == rt_addr_q)) begin
                fwd_rt = mem_wb_data;
            end else if (wb_wb_en && (wb_wb_addr == rt_addr_q)) begin
                fwd_rt = wb_wb_data;
            end
        end
    end

    // Load-use detection. The check is conservative: it matches rt even when
    // the ID instruction does not read rt.
    always_comb begin
        ex_load_pending = valid_q && is_load_q && wb_en_q && (wb_addr_q != 5'd0);
        rs_hit          = (wb_addr_q == id_rs_addr);
        rt_hit          = (wb_addr_q == id_rt_addr);
        load_use_stall  = ex_load_pending && id_valid && (rs_hit || rt_hit);
    end

    // Next-state selection in priority order: flush, stall, bubble, load.
    always_comb begin
        valid_d   = valid_q;
        pc4_d     = pc4_q;
        rs_addr_d = rs_addr_q;
        rt_addr_d = rt_addr_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        shamt_d   = shamt_q;
        a_sel_d   = a_sel_q;
        b_sel_d   = b_sel_q;
        oper_d    = oper_q;
        wb_en_d   = wb_en_q;
        wb_addr_d = wb_addr_q;
        is_load_d = is_load_q;

        if (ex_flush) begin
            // Kill the slot. Data fields are left as they are.
            valid_d   = 1'b0;
            wb_en_d   = 1'b0;
            is_load_d = 1'b0;
        end else if (ex_stall) begin
            // Hold the slot, but keep any value forwarded this cycle.
            rs_data_d = fwd_rs;
            rt_data_d = fwd_rt;
        end else if (load_use_stall) begin
            // Insert a bubble. The ID instruction is held upstream.
            valid_d   = 1'b0;
            wb_en_d   = 1'b0;
            is_load_d = 1'b0;
        end else begin
            valid_d   = id_valid;
            pc4_d     = id_pc4;
            rs_addr_d = id_rs_addr;
            rt_addr_d = id_rt_addr;
            rs_data_d = id_rs_data;
            rt_data_d = id_rt_data;
            imm_d     = id_imm;
            shamt_d   = id_shamt;
            a_sel_d   = id_a_sel;
            b_sel_d   = id_b_sel;
            oper_d    = id_alu_oper;
            wb_en_d   = id_valid && id_wb_en;
            wb_addr_d = id_wb_addr;
            is_load_d = id_valid && id_is_load;
        end
    end

    // Pipeline register with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            pc4_q     <= 32'd0;
            rs_addr_q <= 5'd0;
            rt_addr_q <= 5'd0;
            rs_data_q <= 32'd0;
            rt_data_q <= 32'd0;
            imm_q     <= 32'd0;
            shamt_q   <= 5'd0;
            a_sel_q   <= 2'd0;
            b_sel_q   <= 1'b0;
            oper_q    <= 4'd0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= 5'd0;
            is_load_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            pc4_q     <= pc4_d;
            rs_addr_q <= rs_addr_d;
            rt_addr_q <= rt_addr_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            shamt_q   <= shamt_d;
            a_sel_q   <= a_sel_d;
            b_sel_q   <= b_sel_d;
            oper_q    <= oper_d;
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            is_load_q <= is_load_d;
        end
    end

    // ALU operand muxing and EX/MEM control outputs
    always_comb begin
        case (a_sel_q)
            A_SEL_RS:    alu_a = fwd_rs;
            A_SEL_SHAMT: alu_a = {27'd0, shamt_q};
            A_SEL_PC4:   alu_a = pc4_q;
            A_SEL_ZERO:  alu_a = 32'd0;
            default:     alu_a = 32'd0;
        endcase
        alu_b         = b_sel_q ? imm_q : fwd_rt;
        ex_store_data = fwd_rt;
        alu_oper      = oper_q;
        ex_valid      = valid_q;
        ex_wb_en      = wb_en_q;
        ex_wb_addr    = wb_addr_q;
        ex_is_load    = is_load_q;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage. It has three parts. The first is a table of
// single-instruction vectors. The second is hand-written multi-cycle corner
// sequences. The third is a randomized run checked against an
// instruction-level model.
module tb_id_ex_stage;

    typedef struct {
        logic        valid;
        logic [31:0] pc4;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic [31:0] imm;
        logic [4:0]  shamt;
        logic [1:0]  a_sel;
        logic        b_sel;
        logic [3:0]  oper;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic        is_load;
    } id_t;

    typedef struct {
        id_t         id;
        logic        m_en;
        logic [4:0]  m_addr;
        logic [31:0] m_data;
        logic        w_en;
        logic [4:0]  w_addr;
        logic [31:0] w_data;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic [31:0] exp_sd;
        logic        exp_valid;
        logic        exp_wb_en;
        logic        exp_is_load;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_pc4;
    logic [4:0]  id_rs_addr;
    logic [4:0]  id_rt_addr;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [31:0] id_imm;
    logic [4:0]  id_shamt;
    logic [1:0]  id_a_sel;
    logic        id_b_sel;
    logic [3:0]  id_alu_oper;
    logic        id_wb_en;
    logic [4:0]  id_wb_addr;
    logic        id_is_load;
    logic        ex_stall;
    logic        ex_flush;
    logic        mem_wb_en;
    logic [4:0]  mem_wb_addr;
    logic [31:0] mem_wb_data;
    logic        wb_wb_en;
    logic [4:0]  wb_wb_addr;
    logic [31:0] wb_wb_data;
    logic        load_use_stall;
    logic        ex_valid;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_oper;
    logic [31:0] ex_store_data;
    logic        ex_wb_en;
    logic [4:0]  ex_wb_addr;
    logic        ex_is_load;

    int          tests_run;
    int          tests_failed;
    logic [31:0] exp_q[$];

    id_ex_stage #(.FWD_EN(1'b1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid       (id_valid),
        .id_pc4         (id_pc4),
        .id_rs_addr     (id_rs_addr),
        .id_rt_addr     (id_rt_addr),
        .id_rs_data     (id_rs_data),
        .id_rt_data     (id_rt_data),
        .id_imm         (id_imm),
        .id_shamt       (id_shamt),
        .id_a_sel       (id_a_sel),
        .id_b_sel       (id_b_sel),
        .id_alu_oper    (id_alu_oper),
        .id_wb_en       (id_wb_en),
        .id_wb_addr     (id_wb_addr),
        .id_is_load     (id_is_load),
        .ex_stall       (ex_stall),
        .ex_flush       (ex_flush),
        .mem_wb_en      (mem_wb_en),
        .mem_wb_addr    (mem_wb_addr),
        .mem_wb_data    (mem_wb_data),
        .wb_wb_en       (wb_wb_en),
        .wb_wb_addr     (wb_wb_addr),
        .wb_wb_data     (wb_wb_data),
        .load_use_stall (load_use_stall),
        .ex_valid       (ex_valid),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .alu_oper       (alu_oper),
        .ex_store_data  (ex_store_data),
        .ex_wb_en       (ex_wb_en),
        .ex_wb_addr     (ex_wb_addr),
        .ex_is_load     (ex_is_load)
    );

    // Clock: 10 time-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic id_t mk_id(input logic v, input logic [31:0] pc4,
                                  input logic [4:0] rs, input logic [31:0] rsd,
                                  input logic [4:0] rt, input logic [31:0] rtd,
                                  input logic [31:0] imm, input logic [4:0] shamt,
                                  input logic [1:0] a_sel, input logic b_sel,
                                  input logic [3:0] oper, input logic wb_en,
                                  input logic [4:0] wb_addr, input logic is_load);
        id_t x;
        x.valid = v;      x.pc4 = pc4;     x.rs = rs;          x.rsd = rsd;
        x.rt = rt;        x.rtd = rtd;     x.imm = imm;        x.shamt = shamt;
        x.a_sel = a_sel;  x.b_sel = b_sel; x.oper = oper;      x.wb_en = wb_en;
        x.wb_addr = wb_addr;               x.is_load = is_load;
        return x;
    endfunction

    function automatic vec_t mk_vec(input id_t id,
                                    input logic m_en, input logic [4:0] m_addr, input logic [31:0] m_data,
                                    input logic w_en, input logic [4:0] w_addr, input logic [31:0] w_data,
                                    input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] esd,
                                    input logic ev, input logic ewb, input logic eld);
        vec_t v;
        v.id = id;
        v.m_en = m_en; v.m_addr = m_addr; v.m_data = m_data;
        v.w_en = w_en; v.w_addr = w_addr; v.w_data = w_data;
        v.exp_a = ea;  v.exp_b = eb;      v.exp_sd = esd;
        v.exp_valid = ev; v.exp_wb_en = ewb; v.exp_is_load = eld;
        return v;
    endfunction

    // Driver: present an ID instruction
    task automatic apply_id(input id_t x);
        id_valid    = x.valid;
        id_pc4      = x.pc4;
        id_rs_addr  = x.rs;
        id_rt_addr  = x.rt;
        id_rs_data  = x.rsd;
        id_rt_data  = x.rtd;
        id_imm      = x.imm;
        id_shamt    = x.shamt;
        id_a_sel    = x.a_sel;
        id_b_sel    = x.b_sel;
        id_alu_oper = x.oper;
        id_wb_en    = x.wb_en;
        id_wb_addr  = x.wb_addr;
        id_is_load  = x.is_load;
    endtask

    // Driver: present the MEM and WB forwarding sources
    task automatic set_fwd(input logic me, input logic [4:0] ma, input logic [31:0] md,
                           input logic we, input logic [4:0] wa, input logic [31:0] wd);
        mem_wb_en = me; mem_wb_addr = ma; mem_wb_data = md;
        wb_wb_en  = we; wb_wb_addr  = wa; wb_wb_data  = wd;
    endtask

    // Reference model: one instruction record occupying the EX slot
    id_t  m_slot;
    id_t  m_next;

    // Architectural value of a source register as seen in EX
    function automatic logic [31:0] src_val(input logic [4:0] addr, input logic [31:0] captured);
        if (addr == 5'd0)                                return captured;
        if (mem_wb_en && mem_wb_addr == addr)            return mem_wb_data;
        if (wb_wb_en && wb_wb_addr == addr)              return wb_wb_data;
        return captured;
    endfunction

    function automatic logic [31:0] model_a(input id_t s);
        logic [31:0] r;
        case (s.a_sel)
            2'd0:    r = src_val(s.rs, s.rsd);
            2'd1:    r = 32'(s.shamt);
            2'd2:    r = s.pc4;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic model_lu(input id_t s);
        return s.valid && s.is_load && s.wb_en && (s.wb_addr != 5'd0) && id_valid &&
               ((s.wb_addr == id_rs_addr) || (s.wb_addr == id_rt_addr));
    endfunction

    vec_t vecs[9];

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        ex_stall     = 1'b0;
        ex_flush     = 1'b0;
        apply_id(mk_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        set_fwd(0, 0, 0, 0, 0, 0);

        // Vector table: ID instruction, forwarding seen in EX, expected EX outputs
        vecs[0] = mk_vec(mk_id(1, 32'h100, 1, 5, 2, 7, 0, 0, 0, 0, 4'h2, 1, 3, 0),
                         0, 0, 0, 0, 0, 0, 32'd5, 32'd7, 32'd7, 1, 1, 0);
        vecs[1] = mk_vec(mk_id(1, 32'h104, 3, 1, 0, 0, 32'h8, 0, 0, 1, 4'h3, 1, 4, 0),
                         1, 3, 32'h11, 1, 3, 32'h22, 32'h11, 32'h8, 32'h0, 1, 1, 0);
        vecs[2] = mk_vec(mk_id(1, 32'h108, 0, 0, 0, 0, 0, 0, 0, 0, 4'h4, 0, 0, 0),
                         1, 0, 32'h33, 1, 0, 32'h33, 32'h0, 32'h0, 32'h0, 1, 0, 0);
        vecs[3] = mk_vec(mk_id(1, 32'h10c, 0, 32'hdead, 6, 32'h10, 0, 4, 1, 0, 4'h5, 1, 9, 0),
                         0, 0, 0, 0, 0, 0, 32'h4, 32'h10, 32'h10, 1, 1, 0);
        vecs[4] = mk_vec(mk_id(1, 32'h400, 1, 1, 7, 32'h55, 32'hffff_fffc, 0, 2, 1, 4'h6, 1, 31, 0),
                         0, 0, 0, 1, 7, 32'h77, 32'h400, 32'hffff_fffc, 32'h77, 1, 1, 0);
        vecs[5] = mk_vec(mk_id(1, 32'h110, 1, 9, 2, 1, 0, 0, 3, 0, 4'h7, 0, 0, 0),
                         1, 2, 32'h44, 1, 2, 32'h66, 32'h0, 32'h44, 32'h44, 1, 0, 0);
        vecs[6] = mk_vec(mk_id(1, 32'h114, 9, 1, 8, 2, 32'h20, 0, 0, 1, 4'h8, 1, 10, 0),
                         1, 8, 32'h999, 1, 9, 32'h123, 32'h123, 32'h20, 32'h999, 1, 1, 0);
        vecs[7] = mk_vec(mk_id(0, 32'h118, 1, 1, 2, 2, 0, 0, 0, 0, 4'h9, 1, 12, 1),
                         0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[8] = mk_vec(mk_id(1, 32'h11c, 2, 32'h1000, 0, 0, 32'h4, 0, 0, 1, 4'h0, 1, 13, 1),
                         0, 0, 0, 0, 0, 0, 32'h1000, 32'h4, 32'h0, 1, 1, 1);

        // Reset state
        #12;
        check("reset_ex_valid", 32'(ex_valid), 0);
        check("reset_ex_wb_en", 32'(ex_wb_en), 0);
        check("reset_ex_is_load", 32'(ex_is_load), 0);
        check("reset_alu_a", alu_a, 0);
        check("reset_alu_b", alu_b, 0);
        check("reset_store", ex_store_data, 0);
        check("reset_oper", 32'(alu_oper), 0);
        check("reset_lu", 32'(load_use_stall), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven vectors
        for (int i = 0; i < 9; i++) begin
            apply_id(vecs[i].id);
            set_fwd(0, 0, 0, 0, 0, 0);
            @(posedge clk); #1;
            id_valid = 1'b0;
            set_fwd(vecs[i].m_en, vecs[i].m_addr, vecs[i].m_data,
                    vecs[i].w_en, vecs[i].w_addr, vecs[i].w_data);
            #1;
            check($sformatf("vec%0d_valid", i), 32'(ex_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_wb_en", i), 32'(ex_wb_en), 32'(vecs[i].exp_wb_en));
            check($sformatf("vec%0d_is_load", i), 32'(ex_is_load), 32'(vecs[i].exp_is_load));
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d_alu_a", i), alu_a, vecs[i].exp_a);
                check($sformatf("vec%0d_alu_b", i), alu_b, vecs[i].exp_b);
                check($sformatf("vec%0d_store", i), ex_store_data, vecs[i].exp_sd);
                check($sformatf("vec%0d_oper", i), 32'(alu_oper), 32'(vecs[i].id.oper));
            end
        end
        set_fwd(0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;

        // Asynchronous reset mid-stream
        apply_id(mk_id(1, 32'h200, 1, 5, 2, 7, 0, 0, 0, 0, 4'h2, 1, 3, 0));
        @(posedge clk); #1;
        id_valid = 1'b0;
        #1;
        check("amid_valid_before", 32'(ex_valid), 1);
        rst_n = 1'b0;
        #1;
        check("amid_valid", 32'(ex_valid), 0);
        check("amid_wb_en", 32'(ex_wb_en), 0);
        check("amid_alu_a", alu_a, 0);
        check("amid_alu_b", alu_b, 0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Load-use: one bubble, then the value arrives via WB forwarding
        apply_id(mk_id(1, 32'h300, 0, 0, 0, 0, 32'h0, 0, 0, 1, 4'h0, 1, 4, 1));
        @(posedge clk); #1;
        apply_id(mk_id(1, 32'h304, 4, 0, 1, 3, 0, 0, 0, 0, 4'h2, 1, 6, 0));
        #1;
        check("lu_stall", 32'(load_use_stall), 1);
        @(posedge clk); #1;
        check("lu_bubble_valid", 32'(ex_valid), 0);
        check("lu_bubble_wb_en", 32'(ex_wb_en), 0);
        check("lu_released", 32'(load_use_stall), 0);
        @(posedge clk); #1;
        id_valid = 1'b0;
        set_fwd(0, 0, 0, 1, 4, 32'hABCD);
        #1;
        check("lu_dep_valid", 32'(ex_valid), 1);
        check("lu_dep_alu_a", alu_a, 32'hABCD);
        set_fwd(0, 0, 0, 0, 0, 0);

        // Stall captures a value forwarded only in the first stalled cycle
        apply_id(mk_id(1, 32'h400, 5, 1, 0, 0, 0, 0, 0, 0, 4'h1, 1, 7, 0));
        @(posedge clk); #1;
        id_valid = 1'b0;
        ex_stall = 1'b1;
        set_fwd(0, 0, 0, 1, 5, 32'h99);
        #1;
        check("stall_c1_alu_a", alu_a, 32'h99);
        @(posedge clk); #1;
        set_fwd(0, 0, 0, 0, 0, 0);
        #1;
        check("stall_c2_alu_a", alu_a, 32'h99);
        check("stall_c2_valid", 32'(ex_valid), 1);
        ex_stall = 1'b0;

        // Flush beats stall; the shift operands are checked before the flush
        apply_id(mk_id(1, 32'h500, 0, 0, 8, 32'h10, 0, 4, 1, 0, 4'h4, 1, 8, 0));
        @(posedge clk); #1;
        check("fs_shift_alu_a", alu_a, 32'h4);
        check("fs_shift_alu_b", alu_b, 32'h10);
        check("fs_valid_before", 32'(ex_valid), 1);
        apply_id(mk_id(1, 32'h504, 1, 1, 2, 2, 0, 0, 0, 0, 4'h1, 1, 9, 1));
        ex_flush = 1'b1;
        ex_stall = 1'b1;
        @(posedge clk); #1;
        check("fs_valid", 32'(ex_valid), 0);
        check("fs_wb_en", 32'(ex_wb_en), 0);
        check("fs_is_load", 32'(ex_is_load), 0);
        ex_flush = 1'b0;
        ex_stall = 1'b0;
        id_valid = 1'b0;

        // Randomized run against the instruction-level model
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        m_slot = mk_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        for (int c = 0; c < 400; c++) begin
            apply_id(mk_id($urandom_range(0, 3) != 0, $urandom(),
                           5'($urandom_range(0, 7)), $urandom(),
                           5'($urandom_range(0, 7)), $urandom(),
                           $urandom(), 5'($urandom_range(0, 31)),
                           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                           4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                           5'($urandom_range(0, 7)), $urandom_range(0, 2) == 0));
            set_fwd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom());
            ex_flush = ($urandom_range(0, 9) == 0);
            ex_stall = ($urandom_range(0, 5) == 0);
            #1;
            check("rnd_valid", 32'(ex_valid), 32'(m_slot.valid));
            check("rnd_wb_en", 32'(ex_wb_en), 32'(m_slot.wb_en));
            check("rnd_is_load", 32'(ex_is_load), 32'(m_slot.is_load));
            check("rnd_lu", 32'(load_use_stall), 32'(model_lu(m_slot)));
            if (m_slot.valid) begin
                exp_q.push_back(model_a(m_slot));
                exp_q.push_back(m_slot.b_sel ? m_slot.imm : src_val(m_slot.rt, m_slot.rtd));
                exp_q.push_back(src_val(m_slot.rt, m_slot.rtd));
                check("rnd_alu_a", alu_a, exp_q.pop_front());
                check("rnd_alu_b", alu_b, exp_q.pop_front());
                check("rnd_store", ex_store_data, exp_q.pop_front());
                check("rnd_oper", 32'(alu_oper), 32'(m_slot.oper));
                check("rnd_wb_addr", 32'(ex_wb_addr), 32'(m_slot.wb_addr));
            end
            // What the EX slot holds after this edge
            m_next = m_slot;
            if (ex_flush) begin
                m_next.valid = 1'b0; m_next.wb_en = 1'b0; m_next.is_load = 1'b0;
            end else if (ex_stall) begin
                m_next.rsd = src_val(m_slot.rs, m_slot.rsd);
                m_next.rtd = src_val(m_slot.rt, m_slot.rtd);
            end else if (model_lu(m_slot)) begin
                m_next.valid = 1'b0; m_next.wb_en = 1'b0; m_next.is_load = 1'b0;
            end else begin
                m_next = mk_id(id_valid, id_pc4, id_rs_addr, id_rs_data, id_rt_addr, id_rt_data,
                               id_imm, id_shamt, id_a_sel, id_b_sel, id_alu_oper,
                               id_valid && id_wb_en, id_wb_addr, id_valid && id_is_load);
            end
            @(posedge clk); #1;
            m_slot = m_next;
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
